instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: registered PC drives instruction memory, fetched
// words go into a 2-entry {pc, instr} FIFO drained by the decode stage.
// Redirects flush the buffer and restart fetch at a word-aligned target.
// Optional feature: define IFU_HALT_DETECT_EN to stop fetching on an all-zero
// instruction word (the word is not buffered and the unit enters HALTED).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        imem_en,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] slot0Pc_q, slot0Pc_d, slot0Instr_q, slot0Instr_d;
  logic [31:0] slot1Pc_q, slot1Pc_d, slot1Instr_q, slot1Instr_d;

  logic fetchEn;
  logic haltHit;
  logic pushEn;
  logic popEn;
  logic unusedRedirectLsbs;

  // Redirect targets are forced to word alignment, so the low bits are dropped.
  assign unusedRedirectLsbs = ^redirect_pc[1:0];

  // Fetch/halt control: fetch only with space known at cycle start, no redirect.
  always_comb begin
    state_d = state_q;
    fetchEn = 1'b0;
    haltHit = 1'b0;
    if (rst_n && !redirect_valid && (state_q == RUN) && (count_q != 2'd2)) begin
      fetchEn = 1'b1;
    end
`ifdef IFU_HALT_DETECT_EN
    haltHit = fetchEn && (imem_data == 32'h0000_0000);
`endif
    if (redirect_valid) begin
      state_d = RUN;
    end else if (haltHit) begin
      state_d = HALTED;
    end
  end

  assign pushEn = fetchEn && !haltHit;
  assign popEn  = if_valid && if_ready && !redirect_valid;

  // FIFO and PC next-state: slot0 is always the head; pops shift slot1 down.
  always_comb begin
    pc_d         = pc_q;
    count_d      = count_q;
    slot0Pc_d    = slot0Pc_q;
    slot0Instr_d = slot0Instr_q;
    slot1Pc_d    = slot1Pc_q;
    slot1Instr_d = slot1Instr_q;
    if (redirect_valid) begin
      count_d = 2'd0;
      pc_d    = {redirect_pc[31:2], 2'b00};
    end else begin
      if (pushEn) begin
        pc_d = pc_q + 32'd4;
      end
      case ({popEn, pushEn})
        2'b11: begin
          slot0Pc_d    = pc_q;
          slot0Instr_d = imem_data;
        end
        2'b10: begin
          slot0Pc_d    = slot1Pc_q;
          slot0Instr_d = slot1Instr_q;
          count_d      = count_q - 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd0) begin
            slot0Pc_d    = pc_q;
            slot0Instr_d = imem_data;
          end else begin
            slot1Pc_d    = pc_q;
            slot1Instr_d = imem_data;
          end
          count_d = count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      count_q      <= 2'd0;
      slot0Pc_q    <= 32'd0;
      slot0Instr_q <= 32'd0;
      slot1Pc_q    <= 32'd0;
      slot1Instr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      slot0Pc_q    <= slot0Pc_d;
      slot0Instr_q <= slot0Instr_d;
      slot1Pc_q    <= slot1Pc_d;
      slot1Instr_q <= slot1Instr_d;
    end
  end

  assign imem_addr = pc_q;
  assign imem_en   = fetchEn;
  assign if_valid  = (count_q != 2'd0);
  assign if_instr  = slot0Instr_q;
  assign if_pc     = slot0Pc_q;

`ifdef IFU_HALT_DETECT_EN
  assign halted = (state_q == HALTED);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: queue-based reference model plus directed
// literal scenarios and a randomized phase. Honours IFU_HALT_DETECT_EN.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFU_HALT_DETECT_EN
  localparam bit HALT_DET = 1'b1;
`else
  localparam bit HALT_DET = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_en;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  logic [31:0] mem [0:63];

  int nChecks = 0;
  int nFails  = 0;

  logic [31:0] mPc;
  logic [31:0] qPc[$];
  logic [31:0] qIns[$];
  bit          mHalted = 1'b0;
  bit          modelLive = 1'b0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[7:2]];

  instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .imem_en(imem_en),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halted(halted)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rdy, input logic redir, input logic [31:0] rpc);
    rst_n          = rst;
    if_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
  endtask

  // Reference model: a plain queue of {pc, instr} updated once per rising edge.
  task automatic modelStep();
    bit          doFetch;
    logic [31:0] w;
    if (!rst_n) begin
      mPc = RESET_PC;
      qPc.delete();
      qIns.delete();
      mHalted   = 1'b0;
      modelLive = 1'b1;
    end else if (modelLive) begin
      doFetch = !mHalted && (qPc.size() < 2) && !redirect_valid;
      if (redirect_valid) begin
        qPc.delete();
        qIns.delete();
        mPc     = {redirect_pc[31:2], 2'b00};
        mHalted = 1'b0;
      end else begin
        w = mem[mPc[7:2]];
        if ((qPc.size() > 0) && if_ready) begin
          void'(qPc.pop_front());
          void'(qIns.pop_front());
        end
        if (doFetch) begin
          if (HALT_DET && (w == 32'h0)) begin
            mHalted = 1'b1;
          end else begin
            qPc.push_back(mPc);
            qIns.push_back(w);
            mPc = mPc + 32'd4;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  // Compare process: every cycle, check DUT outputs against the model.
  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("model if_valid", {31'd0, if_valid}, {31'd0, (qPc.size() != 0)});
      if (qPc.size() != 0) begin
        checkOutput("model if_instr", if_instr, qIns[0]);
        checkOutput("model if_pc", if_pc, qPc[0]);
      end
      checkOutput("model imem_addr", imem_addr, mPc);
      checkOutput("model imem_en", {31'd0, imem_en},
                  {31'd0, (rst_n && !redirect_valid && !mHalted && (qPc.size() < 2))});
      checkOutput("model halted", {31'd0, halted}, {31'd0, mHalted});
    end
  end

  initial begin
    logic [31:0] prog [0:5];
    logic [31:0] v;
    prog[0] = 32'h0000_0093; prog[1] = 32'h0010_0113; prog[2] = 32'h0020_8193;
    prog[3] = 32'h0031_0213; prog[4] = 32'h0031_2133; prog[5] = 32'h0041_8293;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      if ($urandom_range(0, 7) == 0) v = 32'h0;
      else if (v == 32'h0) v = 32'h1;
      mem[i] = v;
    end
    for (int i = 0; i < 6; i++) mem[i] = prog[i];
    mem[6]  = 32'h0000_0000;
    mem[63] = 32'hDEAD_BEEF;

    // Reset, then stream the program with a consumer that is always ready.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("reset if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("reset if_instr", if_instr, 32'h0);
    checkOutput("reset if_pc", if_pc, 32'h0);
    checkOutput("reset halted", {31'd0, halted}, 32'd0);
    checkOutput("reset imem_addr", imem_addr, RESET_PC);
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      checkOutput("stream if_instr", if_instr, prog[k]);
      checkOutput("stream if_pc", if_pc, 32'(4 * k));
    end

    // Stalled consumer: buffer fills to two entries and fetch stops.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall imem_en", {31'd0, imem_en}, 32'd0);
      checkOutput("stall imem_addr", imem_addr, 32'h8);
      checkOutput("stall if_instr", if_instr, 32'h0000_0093);
      tick();
    end

    // Redirect to a misaligned target while full and ready: flush, no pop.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0007);
    @(negedge clk);
    checkOutput("redirect imem_en", {31'd0, imem_en}, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("redirect if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("redirect imem_addr", imem_addr, 32'h4);
    checkOutput("redirect halted", {31'd0, halted}, 32'd0);
    tick();
    @(negedge clk);
    checkOutput("redirect head pc", if_pc, 32'h4);
    checkOutput("redirect head instr", if_instr, 32'h0010_0113);

`ifdef IFU_HALT_DETECT_EN
    // Zero word at address 24 stops fetch once the program has drained.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (7) tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("halt if_valid", {31'd0, if_valid}, 32'd0);
      checkOutput("halt halted", {31'd0, halted}, 32'd1);
      checkOutput("halt imem_addr", imem_addr, 32'd24);
      checkOutput("halt imem_en", {31'd0, imem_en}, 32'd0);
      tick();
    end
`endif

    // Mid-stream reset with one buffered entry, then PC wrap at the top.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("midreset if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("midreset imem_addr", imem_addr, RESET_PC);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("wrap imem_addr top", imem_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    checkOutput("wrap imem_addr", imem_addr, 32'h0);
    checkOutput("wrap if_pc", if_pc, 32'hFFFF_FFFC);
    checkOutput("wrap if_instr", if_instr, 32'hDEAD_BEEF);

    // Randomized traffic: back-pressure, redirects and occasional resets.
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 19) == 0), 32'($urandom_range(0, 255)));
      tick();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
